// File: rtl/uart_tx_feeder_if.sv
// Host-write and UART-strobe signal bundle for uart_tx_feeder.
// The slave modport is the feeder itself; the master modport is whoever drives it.
interface uart_tx_feeder_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic [DEPTH_LOG2:0]   level;
    logic                  xmitH;
    logic [7:0]            xmit_dataH;
    logic                  xmit_doneH;
    logic                  busy;
    logic                  ovf_err;
    logic                  timeout_err;
    logic                  clr_err;
    logic [1:0]            dbg_state;

    // Handshake: a byte is offered by wr_en for exactly the cycle it is high and is
    // taken unless full was high before that edge; xmitH is a one-cycle start strobe
    // and the feeder then waits for a level-sampled xmit_doneH before the next strobe.
    modport slave (
        input  wr_en, wr_data, xmit_doneH, clr_err,
        output full, level, xmitH, xmit_dataH, busy, ovf_err, timeout_err, dbg_state
    );

    modport master (
        output wr_en, wr_data, xmit_doneH, clr_err,
        input  full, level, xmitH, xmit_dataH, busy, ovf_err, timeout_err, dbg_state
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus issue sequencer in front of a UART transmitter: strobes one byte,
// ignores done for a guard window, then waits for done or times out.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GUARD      = 2,
    parameter int TIMEOUT    = 20000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_l,
    uart_tx_feeder_if.slave  bus
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int CNT_MAX = (GUARD > TIMEOUT) ? GUARD : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GUARD_WAIT = 2'd1,
        DONE_WAIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pop;
    logic                  tmo_hit;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  full_q, full_d;
    logic                  xmit_q, xmit_d;
    logic [7:0]            xdata_q, xdata_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    logic                  tmo_q, tmo_d;
    logic                  push;
    logic                  full_now;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One shared down-counter serves both the guard window and the done timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        tmo_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    cnt_d   = CW'(GUARD);
                    state_d = GUARD_WAIT;
                end
            end
            GUARD_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = CW'(TIMEOUT);
                    state_d = DONE_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE_WAIT: begin
                if (bus.xmit_doneH) begin
                    state_d = IDLE;
                end else if (cnt_q <= CW'(1)) begin
                    tmo_hit = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // full is judged on the pre-edge occupancy, so a same-edge pop never rescues a write.
    always_comb begin
        full_now = (level_q == LVL_FULL);
        push     = bus.wr_en && !full_now;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LVL_FULL);
        xmit_d  = pop;
        xdata_d = pop ? mem_q[rd_ptr_q] : xdata_q;
        busy_d  = (state_d != IDLE) || (level_d != '0);
        ovf_d   = (bus.wr_en && full_now) || (ovf_q && !bus.clr_err);
        tmo_d   = tmo_hit || (tmo_q && !bus.clr_err);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            xmit_q   <= 1'b0;
            xdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            xmit_q   <= xmit_d;
            xdata_q  <= xdata_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full        = full_q;
    assign bus.level       = level_q;
    assign bus.xmitH       = xmit_q;
    assign bus.xmit_dataH  = xdata_q;
    assign bus.busy        = busy_q;
    assign bus.ovf_err     = ovf_q;
    assign bus.timeout_err = tmo_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a transaction-level timing model predicts occupancy,
// strobe cycles and flags; a byte scoreboard checks what the UART receives.
module tb_uart_tx_feeder;
    localparam int DL      = 4;
    localparam int DEPTH   = 16;
    localparam int GUARD   = 2;
    localparam int TIMEOUT = 8;

    logic sys_clk   = 1'b0;
    logic sys_rst_l = 1'b0;

    uart_tx_feeder_if #(.DEPTH_LOG2(DL)) bus ();

    uart_tx_feeder #(
        .DEPTH_LOG2 (DL),
        .GUARD      (GUARD),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .bus       (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The transmitter is "engaged" from a pop until done is seen or the wait expires;
    // age counts edges since the pop, done only counts once age exceeds GUARD.
    int m_level;
    bit m_engaged;
    int m_age;
    bit m_strobe;
    bit m_ovf;
    bit m_tmo;

    task automatic model_reset();
        m_level   = 0;
        m_engaged = 0;
        m_age     = 0;
        m_strobe  = 0;
        m_ovf     = 0;
        m_tmo     = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit was_full;
        bit popped;
        bit ovf_set;
        bit tmo_set;
        was_full = (m_level == DEPTH);
        popped   = 0;
        ovf_set  = 0;
        tmo_set  = 0;
        if (m_engaged) begin
            m_age++;
            if (m_age > GUARD) begin
                if (bus.xmit_doneH) begin
                    m_engaged = 0;
                end else if (m_age == GUARD + TIMEOUT) begin
                    m_engaged = 0;
                    tmo_set   = 1;
                end
            end
        end else if (m_level > 0) begin
            popped    = 1;
            m_engaged = 1;
            m_age     = 0;
        end
        if (bus.wr_en) begin
            if (was_full) begin
                ovf_set = 1;
            end else begin
                m_level++;
                exp_q.push_back(bus.wr_data);
            end
        end
        if (popped) m_level--;
        m_strobe = popped;
        m_ovf    = ovf_set || (m_ovf && !bus.clr_err);
        m_tmo    = tmo_set || (m_tmo && !bus.clr_err);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rst_l);
            if (!sys_rst_l) model_reset();
            else            model_step();
        end
    end

    // ---------------- per-cycle status checker ----------------
    initial begin
        forever begin
            @(negedge sys_clk);
            chk("xmitH",       32'(bus.xmitH),       32'(m_strobe));
            chk("level",       32'(bus.level),       m_level);
            chk("full",        32'(bus.full),        32'(m_level == DEPTH));
            chk("busy",        32'(bus.busy),        32'(m_engaged || (m_level != 0)));
            chk("ovf_err",     32'(bus.ovf_err),     32'(m_ovf));
            chk("timeout_err", 32'(bus.timeout_err), 32'(m_tmo));
            if (!sys_rst_l) chk("reset_xmit_dataH", 32'(bus.xmit_dataH), 32'h00);
        end
    end

    // ---------------- strobe monitor ----------------
    initial begin
        forever begin
            @(negedge sys_clk);
            if (bus.xmitH === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(bus.xmit_dataH), 32'hFFFF_FFFF);
                end else begin
                    chk("xmit_dataH", 32'(bus.xmit_dataH), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic clr_pulse();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.wr_en      = 1'b0;
        bus.wr_data    = 8'h00;
        bus.xmit_doneH = 1'b0;
        bus.clr_err    = 1'b0;
        sys_rst_l      = 1'b0;
        tick(3);
        sys_rst_l = 1'b1;
        tick(2);

        // reset and single byte, done raised from k+5
        wr(8'hA5);
        tick(4);
        bus.xmit_doneH = 1'b1;
        tick(10);
        bus.xmit_doneH = 1'b0;

        // burst ordering, done pulsed on each DONE_WAIT entry
        for (int i = 1; i <= 16; i++) wr(8'(i));
        for (int i = 0; i < 90; i++) begin
            bus.xmit_doneH = (bus.dbg_state == 2'd2);
            tick();
        end
        bus.xmit_doneH = 1'b0;
        tick(3);

        // overflow: stalled UART, writes beyond capacity are dropped
        for (int i = 0; i < 22; i++) wr(8'($urandom_range(0, 255)));
        tick(2);
        clr_pulse();
        bus.xmit_doneH = 1'b1;
        tick(100);
        bus.xmit_doneH = 1'b0;

        // guard: done held high through both transfers
        bus.xmit_doneH = 1'b1;
        wr(8'h11);
        wr(8'h22);
        tick(15);
        bus.xmit_doneH = 1'b0;

        // timeout: no done ever, second byte still goes out, first not repeated
        wr(8'h3C);
        wr(8'h7E);
        tick(30);
        clr_pulse();
        tick(2);

        // reset in the middle of DONE_WAIT with bytes queued
        for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
        tick(2);
        @(posedge sys_clk);
        #3;
        sys_rst_l = 1'b0;
        tick(3);
        sys_rst_l = 1'b1;
        tick(20);
        wr(8'h5A);
        bus.xmit_doneH = 1'b1;
        tick(10);
        bus.xmit_doneH = 1'b0;

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            bus.wr_en      = ($urandom_range(0, 99) < 40);
            bus.wr_data    = 8'($urandom_range(0, 255));
            bus.xmit_doneH = ($urandom_range(0, 3) == 0);
            bus.clr_err    = ($urandom_range(0, 31) == 0);
            tick();
        end

        // drain
        bus.wr_en      = 1'b0;
        bus.clr_err    = 1'b0;
        bus.xmit_doneH = 1'b1;
        tick(100);
        chk("drained_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
